// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: opcodes, arithmetic-unit
// select codes, the sequencer state type and the overflow operand-sign helper.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_INC = 3'b011;
    localparam logic [2:0] OP_DEC = 3'b100;
    localparam logic [2:0] OP_TFR = 3'b101;

    localparam logic [1:0] AU_S_ADD = 2'b00;
    localparam logic [1:0] AU_S_SUB = 2'b01;
    localparam logic [1:0] AU_S_INC = 2'b10;
    localparam logic [1:0] AU_S_DEC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Sign bit of the effective second operand b' seen by the adder for each opcode.
    function automatic logic eff_b_sign(input logic [2:0] op, input logic b_msb);
        case (op)
            OP_ADD, OP_ADC: eff_b_sign = b_msb;
            OP_SUB:         eff_b_sign = ~b_msb;
            OP_DEC:         eff_b_sign = 1'b1;
            default:        eff_b_sign = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_op_decode.sv
// Combinational opcode decode: arithmetic-unit select and carry-in for the first pass.
// Reserved opcodes fall through to TFR (pass A through with no carry).
module alu_seq_op_decode (
    input  logic [2:0] i_op,
    input  logic       i_cin,
    output logic [1:0] o_au_s,
    output logic       o_cin0
);
    import alu_seq_pkg::*;

    always_comb begin
        o_au_s = AU_S_INC;
        o_cin0 = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_au_s = AU_S_ADD;
                o_cin0 = 1'b0;
            end
            OP_ADC: begin
                o_au_s = AU_S_ADD;
                o_cin0 = i_cin;
            end
            OP_SUB: begin
                o_au_s = AU_S_SUB;
                o_cin0 = 1'b1;
            end
            OP_INC: begin
                o_au_s = AU_S_INC;
                o_cin0 = 1'b1;
            end
            OP_DEC: begin
                o_au_s = AU_S_DEC;
                o_cin0 = 1'b0;
            end
            default: begin
                o_au_s = AU_S_INC;
                o_cin0 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Nibble-serial ALU sequencer driving an external 4-bit arithmetic unit, one pass per cycle.
// Optional signed-overflow output res_ovf is built when ALU_SEQ_OVF_EN is defined.
module alu_sequencer #(
    parameter  int NIBBLES = 2,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic         cmd_cin,
    output logic [3:0]   au_a,
    output logic [3:0]   au_b,
    output logic [1:0]   au_s,
    output logic         au_cin,
    input  logic [3:0]   au_d,
    input  logic         au_cout,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_carry,
    output logic         res_zero
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic         res_ovf
`endif
);
    import alu_seq_pkg::*;

    localparam int PW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    seq_state_t     r_state;
    seq_state_t     w_state_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [2:0]     r_op;
    logic           r_cin;
    logic [PW-1:0]  r_pass;
    logic [W-1:0]   r_res;
    logic           r_carry;
    logic           r_zero;

    logic [1:0]     w_dec_s;
    logic           w_dec_cin0;
    logic [3:0]     w_nib_a;
    logic [3:0]     w_nib_b;
    logic [W-1:0]   w_res_next;
    logic           w_last;

    alu_seq_op_decode u_decode (
        .i_op   (r_op),
        .i_cin  (r_cin),
        .o_au_s (w_dec_s),
        .o_cin0 (w_dec_cin0)
    );

    assign w_last = (r_pass == PW'(NIBBLES - 1));

    // Select the operand nibbles for the current pass and merge the returned nibble.
    always_comb begin
        w_nib_a    = 4'h0;
        w_nib_b    = 4'h0;
        w_res_next = r_res;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_pass == PW'(i)) begin
                w_nib_a              = r_a[4*i +: 4];
                w_nib_b              = r_b[4*i +: 4];
                w_res_next[4*i +: 4] = au_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        res_valid    = 1'b0;
        au_a         = 4'h0;
        au_b         = 4'h0;
        au_s         = 2'b00;
        au_cin       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                au_a   = w_nib_a;
                au_b   = w_nib_b;
                au_s   = w_dec_s;
                au_cin = (r_pass == '0) ? w_dec_cin0 : r_carry;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

`ifdef ALU_SEQ_OVF_EN
    logic r_ovf;
    logic w_ovf;

    assign w_ovf   = (r_a[W-1] == eff_b_sign(r_op, r_b[W-1])) && (w_res_next[W-1] != r_a[W-1]);
    assign res_ovf = r_ovf;
`endif

    // Operand latch on acceptance; per-pass result and carry capture in EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 3'b000;
            r_cin   <= 1'b0;
            r_pass  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_a    <= cmd_a;
                        r_b    <= cmd_b;
                        r_op   <= cmd_op;
                        r_cin  <= cmd_cin;
                        r_pass <= '0;
                    end
                end
                ST_EXEC: begin
                    r_res   <= w_res_next;
                    r_carry <= au_cout;
                    r_pass  <= r_pass + PW'(1);
                    if (w_last) begin
                        r_zero <= (w_res_next == '0);
`ifdef ALU_SEQ_OVF_EN
                        r_ovf  <= w_ovf;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign res_data  = r_res;
    assign res_carry = r_carry;
    assign res_zero  = r_zero;

endmodule
